instr_packer: RTL

Instruction encoder for the pipeline CPU's test and boot path: inverse of the immediate generator. Takes decoded fields (format, registers, funct3, signed immediate) over a valid/ready handshake, range-checks the immediate, scatters it into the RV32 I/S/B bit positions, and presents the packed 32-bit word with its instruction-memory byte address. It sits between the program loader and the instruction-memory write port.

---
 rtl/instr_packer_if.sv | 30 +++
 rtl/instr_packer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/instr_packer_if.sv
// Field/handshake bundle between the program loader, instr_packer and the
// instruction-memory write port.
interface instr_packer_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  kind_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    // Loader / memory side: drives fields and out_ready_i, observes results.
    modport master (
        output in_valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, addr_o, err_o, err_cnt_o
    );

    // Packer side.
    modport slave (
        input  in_valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, addr_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/instr_packer.sv
// RV32 I/S/B instruction encoder with immediate range checking and address tracking.
// Optional saturating reject counter enabled by defining INSTR_PACKER_ERR_CNT_EN.
module instr_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    instr_packer_if.slave bus
);

    typedef enum logic [2:0] {
        KIND_IALU = 3'd0,
        KIND_SRAI = 3'd1,
        KIND_LW   = 3'd2,
        KIND_SW   = 3'd3,
        KIND_BEQ  = 3'd4
    } kind_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic        out_valid_q;
    logic [31:0] instr_q;
    logic [31:0] addr_q;
    logic        err_q;

    logic        in_ready;
    logic        accept;
    logic        out_xfer;
    logic        legal;
    logic [31:0] packed_instr;
    logic        fits_12;
    logic        fits_13;
    logic        fits_shamt;
    logic [31:0] imm;

    assign imm = bus.imm_i;

    // Two's complement range checks: all bits above the field's sign bit must
    // match that sign bit.
    assign fits_12    = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13    = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_shamt = ~(|imm[31:5]);

    // Handshake rule on both sides: a word moves on a rising edge where valid
    // and ready are both high; valid never waits on ready, and ready on the
    // input depends only on the output register state, out_ready_i and flush_i.
    assign in_ready = !flush_i && (!out_valid_q || bus.out_ready_i);
    assign accept   = bus.in_valid_i && in_ready;
    assign out_xfer = out_valid_q && bus.out_ready_i;

    always_comb begin
        legal        = 1'b0;
        packed_instr = 32'h0;
        case (kind_e'(bus.kind_i))
            KIND_IALU: begin
                legal        = fits_12 && (bus.funct3_i != 3'b101);
                packed_instr = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OP_IMM};
            end
            KIND_SRAI: begin
                legal        = fits_shamt;
                packed_instr = {7'b0100000, imm[4:0], bus.rs1_i, 3'b101, bus.rd_i, OP_IMM};
            end
            KIND_LW: begin
                legal        = fits_12;
                packed_instr = {imm[11:0], bus.rs1_i, 3'b010, bus.rd_i, OP_LOAD};
            end
            KIND_SW: begin
                legal        = fits_12;
                packed_instr = {imm[11:5], bus.rs2_i, bus.rs1_i, 3'b010, imm[4:0], OP_STORE};
            end
            KIND_BEQ: begin
                legal        = fits_13 && !imm[0];
                packed_instr = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, 3'b000,
                                imm[4:1], imm[11], OP_BRANCH};
            end
            default: begin
                legal        = 1'b0;
                packed_instr = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_q <= 1'b0;
            instr_q     <= 32'h0;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
            addr_q      <= BASE_ADDR;
            err_q       <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            // addr_q names the word in instr_q, so it advances when that word leaves.
            if (out_xfer) begin
                addr_q <= addr_q + 32'd4;
            end
            if (accept && legal) begin
                out_valid_q <= 1'b1;
                instr_q     <= packed_instr;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef INSTR_PACKER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Survives flush; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_cnt_q <= 8'h00;
        end else if (accept && !legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt_o = err_cnt_q;
`else
    assign bus.err_cnt_o = 8'h00;
`endif

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.instr_o     = instr_q;
    assign bus.addr_o      = addr_q;
    assign bus.err_o       = err_q;

endmodule
